mmr_ctrl: RTL and testbench

MMR_CTRL -- requirements
Module: mmr_ctrl

---
 rtl/cpu_params_pkg.sv | 27 ++
 rtl/mmr_decode.sv | 32 +++
 rtl/mmr_ctrl.sv | 129 ++++++++++++
 tb/tb_mmr_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg: machine-timer MMR window constants, register width and controller state type
package cpu_params_pkg;

    localparam int RSZ = 32;

    localparam logic [31:0] MMR_BASE        = 32'h0200_0000;
    localparam logic [15:0] OFS_MSIP        = 16'h0000;
    localparam logic [15:0] OFS_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] OFS_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] OFS_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] OFS_MTIME_HI    = 16'hBFFC;

    // Bit positions of the one-hot register select
    localparam int SEL_MSIP  = 0;
    localparam int SEL_CMPLO = 1;
    localparam int SEL_CMPHI = 2;
    localparam int SEL_MTLO  = 3;
    localparam int SEL_MTHI  = 4;
    localparam int NSEL      = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } mmr_state_e;

endpackage

// File: rtl/mmr_decode.sv
// mmr_decode: combinational address/size legality check producing a one-hot register select
module mmr_decode
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] MMR_BASE        = cpu_params_pkg::MMR_BASE,
    parameter logic [15:0] OFS_MSIP        = cpu_params_pkg::OFS_MSIP,
    parameter logic [15:0] OFS_MTIMECMP_LO = cpu_params_pkg::OFS_MTIMECMP_LO,
    parameter logic [15:0] OFS_MTIMECMP_HI = cpu_params_pkg::OFS_MTIMECMP_HI,
    parameter logic [15:0] OFS_MTIME_LO    = cpu_params_pkg::OFS_MTIME_LO,
    parameter logic [15:0] OFS_MTIME_HI    = cpu_params_pkg::OFS_MTIME_HI
) (
    input  logic [31:0]     addr,
    input  logic [1:0]      size,
    output logic [NSEL-1:0] sel,
    output logic            legal
);

    logic [NSEL-1:0] hit;

    always_comb begin
        hit            = '0;
        hit[SEL_MSIP]  = addr[15:0] == OFS_MSIP;
        hit[SEL_CMPLO] = addr[15:0] == OFS_MTIMECMP_LO;
        hit[SEL_CMPHI] = addr[15:0] == OFS_MTIMECMP_HI;
        hit[SEL_MTLO]  = addr[15:0] == OFS_MTIME_LO;
        hit[SEL_MTHI]  = addr[15:0] == OFS_MTIME_HI;
        legal = (size == 2'd2) && (addr[1:0] == 2'b00) &&
                (addr[31:16] == MMR_BASE[31:16]) && (|hit);
        sel   = hit & {NSEL{legal}};
    end

endmodule

// File: rtl/mmr_ctrl.sv
// mmr_ctrl: MEM-stage access controller for the machine-timer MMRs, with a coherent
// two-word mtime read via a high-half shadow captured on the low-half read.
module mmr_ctrl
    import cpu_params_pkg::*;
#(
    parameter logic [31:0] MMR_BASE        = cpu_params_pkg::MMR_BASE,
    parameter logic [15:0] OFS_MSIP        = cpu_params_pkg::OFS_MSIP,
    parameter logic [15:0] OFS_MTIMECMP_LO = cpu_params_pkg::OFS_MTIMECMP_LO,
    parameter logic [15:0] OFS_MTIMECMP_HI = cpu_params_pkg::OFS_MTIMECMP_HI,
    parameter logic [15:0] OFS_MTIME_LO    = cpu_params_pkg::OFS_MTIME_LO,
    parameter logic [15:0] OFS_MTIME_HI    = cpu_params_pkg::OFS_MTIME_HI
) (
    input  logic               clk_in,
    input  logic               reset_in,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rd,
    input  logic [31:0]        req_addr,
    input  logic [1:0]         req_size,
    input  logic [RSZ-1:0]     req_wr_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RSZ-1:0]     rsp_rd_data,
    output logic               rsp_err,
    output logic               mtime_lo_wr,
    output logic               mtime_hi_wr,
    output logic               mtimecmp_lo_wr,
    output logic               mtimecmp_hi_wr,
    output logic               msip_wr,
    output logic [RSZ-1:0]     mmr_wr_data,
    input  logic [2*RSZ-1:0]   mtime,
    input  logic [2*RSZ-1:0]   mtimecmp,
    input  logic [RSZ-1:0]     msip_reg
);

    mmr_state_e      state, state_nxt;
    logic [31:0]     addr_q;
    logic [1:0]      size_q;
    logic            rd_q;
    logic [RSZ-1:0]  wdata_q;
    logic [RSZ-1:0]  hi_shadow;
    logic            shadow_vld;
    logic [NSEL-1:0] sel;
    logic            legal;
    logic            wr_en;
    logic [NSEL-1:0] strb;
    logic [RSZ-1:0]  rd_mux;

    mmr_decode #(
        .MMR_BASE        (MMR_BASE),
        .OFS_MSIP        (OFS_MSIP),
        .OFS_MTIMECMP_LO (OFS_MTIMECMP_LO),
        .OFS_MTIMECMP_HI (OFS_MTIMECMP_HI),
        .OFS_MTIME_LO    (OFS_MTIME_LO),
        .OFS_MTIME_HI    (OFS_MTIME_HI)
    ) u_decode (
        .addr  (addr_q),
        .size  (size_q),
        .sel   (sel),
        .legal (legal)
    );

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == IDLE)   ? (req_valid ? ACCESS : IDLE) :
                    (state == ACCESS) ? RESP :
                    (rsp_ready ? IDLE : RESP);
    end

    always_comb begin
        req_ready      = state == IDLE;
        rsp_valid      = state == RESP;
        wr_en          = (state == ACCESS) && !rd_q;
        strb           = sel & {NSEL{wr_en}};
        msip_wr        = strb[SEL_MSIP];
        mtimecmp_lo_wr = strb[SEL_CMPLO];
        mtimecmp_hi_wr = strb[SEL_CMPHI];
        mtime_lo_wr    = strb[SEL_MTLO];
        mtime_hi_wr    = strb[SEL_MTHI];
        mmr_wr_data    = (|strb) ? wdata_q : '0;
    end

    // sel is already zero for an illegal access, so the mux falls through to 0
    always_comb begin
        rd_mux = sel[SEL_MSIP]  ? msip_reg :
                 sel[SEL_CMPLO] ? mtimecmp[RSZ-1:0] :
                 sel[SEL_CMPHI] ? mtimecmp[2*RSZ-1:RSZ] :
                 sel[SEL_MTLO]  ? mtime[RSZ-1:0] :
                 sel[SEL_MTHI]  ? (shadow_vld ? hi_shadow : mtime[2*RSZ-1:RSZ]) :
                 '0;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            addr_q      <= '0;
            size_q      <= '0;
            rd_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_rd_data <= '0;
            rsp_err     <= 1'b0;
            hi_shadow   <= '0;
            shadow_vld  <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                rd_q    <= req_rd;
                wdata_q <= req_wr_data;
            end
            if (state == ACCESS) begin
                rsp_rd_data <= rd_q ? rd_mux : '0;
                rsp_err     <= !legal;
                if (rd_q && sel[SEL_MTLO]) begin
                    hi_shadow  <= mtime[2*RSZ-1:RSZ];
                    shadow_vld <= 1'b1;
                end else if (sel[SEL_MTLO] || sel[SEL_MTHI]) begin
                    shadow_vld <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mmr_ctrl.sv
// tb_mmr_ctrl: directed and randomized accesses checked by a queue scoreboard against
// a register-level model of the timer MMR map.
module tb_mmr_ctrl;

    logic        clk_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rd = 1'b0;
    logic [31:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic [31:0] req_wr_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rd_data;
    logic        rsp_err;
    logic        mtime_lo_wr, mtime_hi_wr, mtimecmp_lo_wr, mtimecmp_hi_wr, msip_wr;
    logic [31:0] mmr_wr_data;
    logic [63:0] mtime = '0;
    logic [63:0] mtimecmp = '0;
    logic [31:0] msip_reg = '0;

    mmr_ctrl dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_rd         (req_rd),
        .req_addr       (req_addr),
        .req_size       (req_size),
        .req_wr_data    (req_wr_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rd_data    (rsp_rd_data),
        .rsp_err        (rsp_err),
        .mtime_lo_wr    (mtime_lo_wr),
        .mtime_hi_wr    (mtime_hi_wr),
        .mtimecmp_lo_wr (mtimecmp_lo_wr),
        .mtimecmp_hi_wr (mtimecmp_hi_wr),
        .msip_wr        (msip_wr),
        .mmr_wr_data    (mmr_wr_data),
        .mtime          (mtime),
        .mtimecmp       (mtimecmp),
        .msip_reg       (msip_reg)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {logic [31:0] data; logic err;} rsp_t;
    typedef struct {logic [4:0] strb; logic [31:0] data;} wr_t;

    rsp_t        rsp_q[$];
    wr_t         wr_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    bit          rr_rand = 1'b0;
    logic [31:0] m_sh = '0;
    bit          m_vld = 1'b0;
    logic [15:0] ofs_tab [5] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC};

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int off_idx(logic [15:0] o);
        for (int i = 0; i < 5; i++)
            if (ofs_tab[i] == o) return i;
        return -1;
    endfunction

    // Register map model: strobe order msip, cmp_lo, cmp_hi, mtime_lo, mtime_hi
    task automatic issue(bit rd, logic [31:0] addr, logic [1:0] size, logic [31:0] wd, bit track = 1'b1);
        int   idx;
        bit   legal;
        rsp_t r;
        wr_t  w;
        int   n;
        @(negedge clk_in);
        idx   = off_idx(addr[15:0]);
        legal = size == 2'd2 && addr[1:0] == 2'b00 && addr[31:16] == 16'h0200 && idx >= 0;
        r.err  = !legal;
        r.data = '0;
        if (legal && rd) begin
            case (idx)
                0: r.data = msip_reg;
                1: r.data = mtimecmp[31:0];
                2: r.data = mtimecmp[63:32];
                3: begin r.data = mtime[31:0]; m_sh = mtime[63:32]; m_vld = 1'b1; end
                default: begin r.data = m_vld ? m_sh : mtime[63:32]; m_vld = 1'b0; end
            endcase
        end
        if (legal && !rd) begin
            w.strb = 5'(1 << idx);
            w.data = wd;
            if (track) wr_q.push_back(w);
            if (idx >= 3) m_vld = 1'b0;
        end
        if (track) rsp_q.push_back(r);
        req_rd      = rd;
        req_addr    = addr;
        req_size    = size;
        req_wr_data = wd;
        req_valid   = 1'b1;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (n == 100) check("accept_timeout", req_ready, 1'b1);
        @(posedge clk_in);
        #1 req_valid = 1'b0;
    endtask

    task automatic read_expect(logic [31:0] addr, logic [31:0] exp, string name);
        issue(1'b1, addr, 2'd2, 32'h0);
        @(posedge clk_in);
        #1 check(name, rsp_rd_data, exp);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk_in);
            n++;
        end
        if (n == 500) check("idle_timeout", 64'(rsp_q.size()), 64'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk_in);
            #2 if (rr_rand) rsp_ready = 1'($urandom_range(0, 1));
        end
    end

    logic [4:0] mon_s;
    wr_t        mon_w;
    rsp_t       mon_r;
    always @(negedge clk_in) begin
        mon_s = {mtime_hi_wr, mtime_lo_wr, mtimecmp_hi_wr, mtimecmp_lo_wr, msip_wr};
        if (mon_s != 5'b0) begin
            if (wr_q.size() == 0) check("unexpected_strobe", mon_s, 5'b0);
            else begin
                mon_w = wr_q.pop_front();
                check("strobe", mon_s, mon_w.strb);
                check("mmr_wr_data", mmr_wr_data, mon_w.data);
            end
        end else if (mmr_wr_data != 32'h0) check("idle_mmr_wr_data", mmr_wr_data, 32'h0);
        if (rsp_valid && rsp_ready) begin
            if (rsp_q.size() == 0) check("unexpected_rsp", rsp_valid, 1'b0);
            else begin
                mon_r = rsp_q.pop_front();
                check("rsp_rd_data", rsp_rd_data, mon_r.data);
                check("rsp_err", rsp_err, mon_r.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int k;
        logic [31:0] a;
        logic [1:0]  sz;
        #12;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_rsp_rd_data", rsp_rd_data, 32'h0);
        check("rst_strobes", {mtime_hi_wr, mtime_lo_wr, mtimecmp_hi_wr, mtimecmp_lo_wr, msip_wr}, 5'b0);
        check("rst_mmr_wr_data", mmr_wr_data, 32'h0);
        @(negedge clk_in) reset_in = 1'b1;

        issue(1'b0, 32'h0200_0000, 2'd2, 32'h1);
        check("msip_wr_n1", msip_wr, 1'b1);
        check("wr_data_n1", mmr_wr_data, 32'h1);
        check("rsp_valid_n1", rsp_valid, 1'b0);
        @(posedge clk_in);
        #1;
        check("rsp_valid_n2", rsp_valid, 1'b1);
        check("msip_wr_n2", msip_wr, 1'b0);
        check("rsp_err_n2", rsp_err, 1'b0);
        wait_idle();

        mtime = 64'h0000_0001_FFFF_FFFF;
        read_expect(32'h0200_BFF8, 32'hFFFF_FFFF, "mtime_lo");
        wait_idle();
        mtime = 64'h0000_0002_0000_0005;
        read_expect(32'h0200_BFFC, 32'h0000_0001, "mtime_hi_shadow");
        wait_idle();
        read_expect(32'h0200_BFFC, 32'h0000_0002, "mtime_hi_live");
        wait_idle();

        issue(1'b0, 32'h0200_4000, 2'd1, 32'hAAAA_5555);
        issue(1'b1, 32'h0200_0010, 2'd2, 32'h0);
        issue(1'b0, 32'h0200_4002, 2'd2, 32'h1234_5678);
        wait_idle();

        mtimecmp = 64'hDEAD_BEEF_0000_0000;
        rsp_ready = 1'b0;
        issue(1'b1, 32'h0200_4004, 2'd2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_in);
            #1;
            check("stall_rsp_valid", rsp_valid, 1'b1);
            check("stall_rd_data", rsp_rd_data, 32'hDEAD_BEEF);
            check("stall_req_ready", req_ready, 1'b0);
            if (i == 3) rsp_ready = 1'b1;
        end
        @(posedge clk_in);
        #1 check("stall_idle", req_ready, 1'b1);
        wait_idle();

        mtime = 64'h0000_0007_0000_0003;
        read_expect(32'h0200_BFF8, 32'h3, "lo_before_wr");
        wait_idle();
        mtime = 64'h0000_0009_0000_0004;
        issue(1'b0, 32'h0200_BFFC, 2'd2, 32'h5);
        wait_idle();
        read_expect(32'h0200_BFFC, 32'h9, "hi_after_wr");
        wait_idle();

        mtime = 64'h0000_0003_0000_0001;
        read_expect(32'h0200_BFF8, 32'h1, "lo_before_rst");
        wait_idle();
        issue(1'b0, 32'h0200_4000, 2'd2, 32'h1234, 1'b0);
        reset_in = 1'b0;
        #1;
        check("rst_cmp_lo_wr", mtimecmp_lo_wr, 1'b0);
        check("rst_access_rsp_valid", rsp_valid, 1'b0);
        check("rst_access_req_ready", req_ready, 1'b1);
        m_vld = 1'b0;
        m_sh  = '0;
        repeat (2) @(negedge clk_in);
        check("rst_hold_rsp_valid", rsp_valid, 1'b0);
        reset_in = 1'b1;
        mtime = 64'h0000_0008_0000_0002;
        read_expect(32'h0200_BFFC, 32'h8, "hi_after_rst");
        wait_idle();

        rr_rand = 1'b1;
        for (int t = 0; t < 200; t++) begin
            if (t % 8 == 0) begin
                wait_idle();
                mtime    = {$urandom, $urandom};
                mtimecmp = {$urandom, $urandom};
                msip_reg = $urandom;
            end
            a  = 32'h0200_0000 | {16'h0, ofs_tab[$urandom_range(0, 4)]};
            sz = 2'd2;
            k  = $urandom_range(0, 9);
            if (k == 0) sz = 2'($urandom_range(0, 1));
            if (k == 1) a[1:0] = 2'($urandom_range(1, 3));
            if (k == 2) a[31:16] = 16'h0300;
            if (k == 3) a[15:0] = a[15:0] + 16'h8;
            issue(1'($urandom_range(0, 1)), a, sz, $urandom);
        end
        wait_idle();
        rr_rand = 1'b0;
        check("rsp_q_drained", 64'(rsp_q.size()), 64'd0);
        check("wr_q_drained", 64'(wr_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
